dmem_mmio_responder: RTL



---
 rtl/dmem_mmio_responder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: combinational loads, clocked stores, MMIO cycle/TOHOST/trace registers.
// Optional store-trace FIFO built only when STORE_TRACE_EN is defined.
module dmem_mmio_responder #(
  parameter int unsigned RAM_AW       = 8,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter bit          TRACE_EN_RST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAddr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        TraceValid,
  input  logic        TraceReady,
  output logic [31:0] TraceAddr,
  output logic [31:0] TraceData,
  output logic        Done,
  output logic        Pass
);

  localparam int unsigned RAM_WORDS = 1 << RAM_AW;

  logic [31:0]       ram [RAM_WORDS];
  logic              ramHit;
  logic              mmioHit;
  logic [RAM_AW-1:0] ramIdx;
  logic [1:0]        regSel;
  logic              wrRam;
  logic              wrTohost;
  logic [31:0]       cycleCnt;
  logic [31:0]       tohost;
  logic [31:0]       statusWord;
  logic [31:0]       ctrlWord;

  assign ramHit   = DataAddr < MMIO_BASE;
  assign mmioHit  = DataAddr[31:4] == MMIO_BASE[31:4];
  assign ramIdx   = DataAddr[RAM_AW+1:2];
  assign regSel   = DataAddr[3:2];
  assign wrRam    = MemWrite && ramHit;
  assign wrTohost = MemWrite && mmioHit && (regSel == 2'd1);

  // RAM has no reset; the reset term only drops a store issued in the reset cycle
  always_ff @(posedge clk) begin
    if (wrRam && !reset) begin
      ram[ramIdx] <= WriteData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleCnt <= '0;
      tohost   <= '0;
      Done     <= 1'b0;
      Pass     <= 1'b0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (wrTohost && !Done && (WriteData != '0)) begin
        tohost <= WriteData;
        Done   <= 1'b1;
        Pass   <= (WriteData == 32'd1);
      end
    end
  end

`ifdef STORE_TRACE_EN
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   fifoAddr [FIFO_DEPTH];
  logic [31:0]   fifoData [FIFO_DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [CW-1:0] count;
  logic          traceEn;
  logic          overflow;
  logic          wrCtrl;
  logic          full;
  logic          pop;
  logic          pushReq;
  logic          pushOk;
  logic          drop;

  assign wrCtrl  = MemWrite && mmioHit && (regSel == 2'd3);
  assign full    = count == CW'(FIFO_DEPTH);
  assign pop     = TraceValid && TraceReady;
  assign pushReq = wrRam && traceEn;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign pushOk  = pushReq && (!full || pop);
  assign drop    = pushReq && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      traceEn  <= TRACE_EN_RST;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      if (pushOk) begin
        wrPtr <= wrPtr + PW'(1);
      end
      case ({pushOk, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wrCtrl) begin
        traceEn <= WriteData[0];
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (wrCtrl && WriteData[1]) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk && !reset) begin
      fifoAddr[wrPtr] <= DataAddr;
      fifoData[wrPtr] <= WriteData;
    end
  end

  assign TraceValid = count != '0;
  assign TraceAddr  = fifoAddr[rdPtr];
  assign TraceData  = fifoData[rdPtr];
  assign statusWord = {16'b0, 8'(count), 6'b0, overflow, traceEn};
  assign ctrlWord   = {31'b0, traceEn};
`else
  logic unusedTraceCfg;

  assign unusedTraceCfg = &{1'b0, TraceReady, TRACE_EN_RST, (FIFO_DEPTH != 0)};
  assign TraceValid     = 1'b0;
  assign TraceAddr      = '0;
  assign TraceData      = '0;
  assign statusWord     = '0;
  assign ctrlWord       = '0;
`endif

  always_comb begin
    ReadData = 32'hDEAD_BEEF;
    if (ramHit) begin
      ReadData = ram[ramIdx];
    end else if (mmioHit) begin
      case (regSel)
        2'd0:    ReadData = cycleCnt;
        2'd1:    ReadData = tohost;
        2'd2:    ReadData = statusWord;
        default: ReadData = ctrlWord;
      endcase
    end
  end

endmodule
